// File: rtl/dest_ip_tbl_arbiter_if.sv
// Bundle of requester A/B handshakes, the shared table port and arbiter status.
// slave = arbiter side, master = requesters plus table side.
interface dest_ip_tbl_arbiter_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5
);
    logic                          a_req;
    logic                          a_wr;
    logic [TBL_ADDR_WIDTH-1:0]     a_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] a_wdata;
    logic                          a_done;
    logic [C_S_AXI_DATA_WIDTH-1:0] a_rdata;
    logic                          a_err;

    logic                          b_req;
    logic                          b_wr;
    logic [TBL_ADDR_WIDTH-1:0]     b_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] b_wdata;
    logic                          b_done;
    logic [C_S_AXI_DATA_WIDTH-1:0] b_rdata;
    logic                          b_err;

    logic                          tbl_rd_req;
    logic                          tbl_wr_req;
    logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr;
    logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data;
    logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data;
    logic                          tbl_rd_ack;
    logic                          tbl_wr_ack;

    logic                          busy;
    logic                          grant_b;

    modport slave (
        input  a_req, a_wr, a_addr, a_wdata,
        output a_done, a_rdata, a_err,
        input  b_req, b_wr, b_addr, b_wdata,
        output b_done, b_rdata, b_err,
        output tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
        output busy, grant_b
    );

    modport master (
        output a_req, a_wr, a_addr, a_wdata,
        input  a_done, a_rdata, a_err,
        output b_req, b_wr, b_addr, b_wdata,
        input  b_done, b_rdata, b_err,
        input  tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        output tbl_rd_data, tbl_rd_ack, tbl_wr_ack,
        input  busy, grant_b
    );
endinterface

// File: rtl/dest_ip_tbl_arbiter.sv
// Round-robin arbiter sharing the destination-IP table port between requesters A and B.
// Defining DEST_IP_TBL_ARB_TIMEOUT_EN adds a WAIT-state timeout that aborts with x_err.
module dest_ip_tbl_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                 AXI_ACLK,
    input  logic                 AXI_RESETN,
    dest_ip_tbl_arbiter_if.slave bus
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = TBL_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_b_q, grant_b_d;
    logic          op_wr_q, op_wr_d;
    logic [AW-1:0] op_addr_q, op_addr_d;
    logic [DW-1:0] op_wdata_q, op_wdata_d;
    logic          early_ack_q, early_ack_d;
    logic [DW-1:0] early_rdata_q, early_rdata_d;
    logic          rd_req_q, rd_req_d;
    logic          wr_req_q, wr_req_d;
    logic          busy_q, busy_d;
    logic          a_done_q, a_done_d;
    logic          b_done_q, b_done_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          ack_match;
    logic [DW-1:0] rd_value;
    logic          finish;
    logic          timed_out;

`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            a_err_q, a_err_d;
    logic            b_err_q, b_err_d;
`endif

    // An ack seen during ISSUE is parked so the WAIT state can still complete on it.
    assign ack_match = op_wr_q ? bus.tbl_wr_ack : bus.tbl_rd_ack;
    assign rd_value  = early_ack_q ? early_rdata_q : bus.tbl_rd_data;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_b_d     = grant_b_q;
        op_wr_d       = op_wr_q;
        op_addr_d     = op_addr_q;
        op_wdata_d    = op_wdata_q;
        early_ack_d   = early_ack_q;
        early_rdata_d = early_rdata_q;
        rd_req_d      = 1'b0;
        wr_req_d      = 1'b0;
        a_done_d      = 1'b0;
        b_done_d      = 1'b0;
        a_rdata_d     = a_rdata_q;
        b_rdata_d     = b_rdata_q;
        finish        = 1'b0;
        timed_out     = 1'b0;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        a_err_d       = a_err_q;
        b_err_d       = b_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant_b_d   = bus.b_req && (!bus.a_req || !last_grant_q);
                    op_wr_d     = grant_b_d ? bus.b_wr    : bus.a_wr;
                    op_addr_d   = grant_b_d ? bus.b_addr  : bus.a_addr;
                    op_wdata_d  = grant_b_d ? bus.b_wdata : bus.a_wdata;
                    rd_req_d    = !op_wr_d;
                    wr_req_d    = op_wr_d;
                    early_ack_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (ack_match) begin
                    early_ack_d   = 1'b1;
                    early_rdata_d = bus.tbl_rd_data;
                end
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: begin
                if (ack_match || early_ack_q)
                    finish = 1'b1;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else
                    cnt_d = cnt_q + 1'b1;
`endif
                if (finish) begin
                    state_d  = DONE;
                    a_done_d = !grant_b_q;
                    b_done_d = grant_b_q;
                    if (!op_wr_q) begin
                        if (grant_b_q) b_rdata_d = timed_out ? '0 : rd_value;
                        else           a_rdata_d = timed_out ? '0 : rd_value;
                    end
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
                    if (grant_b_q) b_err_d = timed_out;
                    else           a_err_d = timed_out;
`endif
                end
            end
            DONE: begin
                last_grant_d = grant_b_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // last_grant resets to B so that A wins the first contested arbitration.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_b_q     <= 1'b0;
            op_wr_q       <= 1'b0;
            op_addr_q     <= '0;
            op_wdata_q    <= '0;
            early_ack_q   <= 1'b0;
            early_rdata_q <= '0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            a_done_q      <= 1'b0;
            b_done_q      <= 1'b0;
            a_rdata_q     <= '0;
            b_rdata_q     <= '0;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            a_err_q       <= 1'b0;
            b_err_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_b_q     <= grant_b_d;
            op_wr_q       <= op_wr_d;
            op_addr_q     <= op_addr_d;
            op_wdata_q    <= op_wdata_d;
            early_ack_q   <= early_ack_d;
            early_rdata_q <= early_rdata_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
            busy_q        <= busy_d;
            a_done_q      <= a_done_d;
            b_done_q      <= b_done_d;
            a_rdata_q     <= a_rdata_d;
            b_rdata_q     <= b_rdata_d;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            a_err_q       <= a_err_d;
            b_err_q       <= b_err_d;
`endif
        end
    end

    assign bus.tbl_rd_req  = rd_req_q;
    assign bus.tbl_wr_req  = wr_req_q;
    assign bus.tbl_rd_addr = op_addr_q;
    assign bus.tbl_wr_addr = op_addr_q;
    assign bus.tbl_wr_data = op_wdata_q;
    assign bus.a_done      = a_done_q;
    assign bus.b_done      = b_done_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.busy        = busy_q;
    assign bus.grant_b     = grant_b_q;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
    assign bus.a_err       = a_err_q;
    assign bus.b_err       = b_err_q;
`else
    assign bus.a_err       = 1'b0;
    assign bus.b_err       = 1'b0;
`endif
endmodule

// File: tb/tb_dest_ip_tbl_arbiter.sv
// Bench for dest_ip_tbl_arbiter: a behavioural table responder plus a reference model
// of table contents, grant order and held read results.
module tb_dest_ip_tbl_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dest_ip_tbl_arbiter_if #(.C_S_AXI_DATA_WIDTH(DW), .TBL_ADDR_WIDTH(AW)) bus ();

    dest_ip_tbl_arbiter #(
        .C_S_AXI_DATA_WIDTH(DW),
        .TBL_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .AXI_ACLK(clk),
        .AXI_RESETN(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_mem [32];
    bit            ref_last_b;
    logic [DW-1:0] exp_a_rdata;
    logic [DW-1:0] exp_b_rdata;

    bit silent   = 1'b0;
    bit force_wr = 1'b0;
    int kick_rd  = 0;
    int kick_wr  = 0;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0A8_0000 | DW'(i * 3);
    endfunction

    // Table model: acks one cycle after a strobe; tasks can mute it or inject acks.
    initial begin
        logic [DW-1:0] mem [32];
        int            seen_rd;
        int            seen_wr;
        bit            rd_p;
        bit            wr_p;
        logic [AW-1:0] ra;
        seen_rd = 0; seen_wr = 0; rd_p = 1'b0; wr_p = 1'b0; ra = '0;
        for (int i = 0; i < 32; i++) mem[i] = init_word(i);
        bus.tbl_rd_ack  = 1'b0;
        bus.tbl_wr_ack  = 1'b0;
        bus.tbl_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (kick_rd != seen_rd) ra = bus.tbl_rd_addr;
            bus.tbl_rd_ack  = rd_p || (kick_rd != seen_rd);
            bus.tbl_wr_ack  = wr_p || force_wr || (kick_wr != seen_wr);
            bus.tbl_rd_data = bus.tbl_rd_ack ? mem[ra] : DW'($urandom());
            seen_rd = kick_rd;
            seen_wr = kick_wr;
            rd_p = 1'b0;
            wr_p = 1'b0;
            @(negedge clk);
            if (!silent) begin
                if (bus.tbl_rd_req === 1'b1) begin
                    rd_p = 1'b1;
                    ra   = bus.tbl_rd_addr;
                end
                if (bus.tbl_wr_req === 1'b1) begin
                    wr_p = 1'b1;
                    mem[bus.tbl_wr_addr] = bus.tbl_wr_data;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.busy, bus.grant_b, bus.tbl_rd_req, bus.tbl_wr_req} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: busy/grant/rd/wr=%b want 0000",
                     {bus.busy, bus.grant_b, bus.tbl_rd_req, bus.tbl_wr_req});
        end
        total++;
        if ({bus.a_done, bus.b_done, bus.a_err, bus.b_err} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_done: done/err=%b want 0000",
                     {bus.a_done, bus.b_done, bus.a_err, bus.b_err});
        end
        total++;
        if ({bus.tbl_rd_addr, bus.tbl_wr_addr, bus.tbl_wr_data} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_tbl: rd_addr=%0d wr_addr=%0d wr_data=%h want 0",
                     bus.tbl_rd_addr, bus.tbl_wr_addr, bus.tbl_wr_data);
        end
        total++;
        if (bus.a_rdata !== '0 || bus.b_rdata !== '0) begin
            bad++;
            $display("[TB] FAIL reset_rdata: a=%h b=%h want 0", bus.a_rdata, bus.b_rdata);
        end
    endtask

    // One uncontested access; the DUT must be in IDLE on entry.
    task automatic run_single(input bit who, input bit wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input string tag);
        logic [DW-1:0] exp_mine, exp_other;
        if (who) begin
            bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = data; bus.b_req = 1'b1;
        end else begin
            bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = data; bus.a_req = 1'b1;
        end
        tick();
        total++;
        if (bus.tbl_wr_req !== wr || bus.tbl_rd_req !== !wr || bus.tbl_rd_addr !== addr ||
            bus.tbl_wr_addr !== addr || bus.tbl_wr_data !== data || bus.grant_b !== who) begin
            bad++;
            $display("[TB] FAIL %s strobe: wr=%b rd=%b raddr=%0d waddr=%0d wdata=%h grant_b=%b want wr=%b addr=%0d wdata=%h grant_b=%b",
                     tag, bus.tbl_wr_req, bus.tbl_rd_req, bus.tbl_rd_addr, bus.tbl_wr_addr,
                     bus.tbl_wr_data, bus.grant_b, wr, addr, data, who);
        end
        tick();
        tick();
        if (wr) ref_mem[addr] = data;
        else if (who) exp_b_rdata = ref_mem[addr];
        else exp_a_rdata = ref_mem[addr];
        exp_mine  = who ? exp_b_rdata : exp_a_rdata;
        exp_other = who ? exp_a_rdata : exp_b_rdata;
        total++;
        if ((who ? bus.b_done : bus.a_done) !== 1'b1 || (who ? bus.a_done : bus.b_done) !== 1'b0 ||
            (who ? bus.b_rdata : bus.a_rdata) !== exp_mine ||
            (who ? bus.a_rdata : bus.b_rdata) !== exp_other || bus.a_err !== 1'b0 || bus.b_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s done: a_done=%b b_done=%b a_rdata=%h b_rdata=%h err=%b%b want requester %0d done, a_rdata=%h b_rdata=%h err=00",
                     tag, bus.a_done, bus.b_done, bus.a_rdata, bus.b_rdata, bus.a_err, bus.b_err,
                     who, who ? exp_other : exp_mine, who ? exp_mine : exp_other);
        end
        if (who) bus.b_req = 1'b0;
        else bus.a_req = 1'b0;
        ref_last_b = who;
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s idle: busy=%b want 0", tag, bus.busy);
        end
    endtask

    task automatic test_write_read();
        run_single(1'b0, 1'b1, 5'd3, 32'h0A00_0001, "a_write3");
        run_single(1'b0, 1'b0, 5'd3, 32'h0, "a_read3");
        total++;
        if (bus.a_rdata !== 32'h0A00_0001) begin
            bad++;
            $display("[TB] FAIL a_read3_value: a_rdata=%h want 0a000001", bus.a_rdata);
        end
    endtask

    task automatic test_random_single(input int n);
        for (int k = 0; k < n; k++)
            run_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 31)), DW'($urandom()), "rand_single");
    endtask

    // Both requesters held high; completions must alternate starting with the non-last owner.
    task automatic test_fairness(input int n);
        bit exp_b;
        int waited;
        logic [DW-1:0] exp_rd;
        bus.a_wr = 1'($urandom_range(0, 1)); bus.a_addr = AW'($urandom_range(0, 31)); bus.a_wdata = DW'($urandom());
        bus.b_wr = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom_range(0, 31)); bus.b_wdata = DW'($urandom());
        bus.a_req = 1'b1;
        bus.b_req = 1'b1;
        exp_b = !ref_last_b;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (bus.a_done !== 1'b1 && bus.b_done !== 1'b1 && waited < 12);
            if (exp_b) begin
                if (bus.b_wr) ref_mem[bus.b_addr] = bus.b_wdata;
                else exp_b_rdata = ref_mem[bus.b_addr];
            end else begin
                if (bus.a_wr) ref_mem[bus.a_addr] = bus.a_wdata;
                else exp_a_rdata = ref_mem[bus.a_addr];
            end
            total++;
            if (bus.a_done !== !exp_b || bus.b_done !== exp_b || waited != (k == 0 ? 3 : 4)) begin
                bad++;
                $display("[TB] FAIL fair_order[%0d]: a_done=%b b_done=%b after %0d cycles want winner=%s after %0d",
                         k, bus.a_done, bus.b_done, waited, exp_b ? "B" : "A", k == 0 ? 3 : 4);
            end
            total++;
            if (bus.a_rdata !== exp_a_rdata || bus.b_rdata !== exp_b_rdata) begin
                bad++;
                $display("[TB] FAIL fair_rdata[%0d]: a=%h b=%h want a=%h b=%h",
                         k, bus.a_rdata, bus.b_rdata, exp_a_rdata, exp_b_rdata);
            end
            exp_rd = DW'($urandom());
            if (exp_b) begin
                bus.b_wr = 1'($urandom_range(0, 1)); bus.b_addr = AW'($urandom_range(0, 31)); bus.b_wdata = exp_rd;
            end else begin
                bus.a_wr = 1'($urandom_range(0, 1)); bus.a_addr = AW'($urandom_range(0, 31)); bus.a_wdata = exp_rd;
            end
            ref_last_b = exp_b;
            exp_b = !exp_b;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
    endtask

    task automatic test_ack_type();
        logic [AW-1:0] addr;
        int            errs;
        addr = AW'($urandom_range(0, 31));
        silent = 1'b1;
        force_wr = 1'b1;
        bus.b_wr = 1'b0; bus.b_addr = addr; bus.b_req = 1'b1;
        tick();
        tick();
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.busy !== 1'b1 || bus.b_done !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL wrong_ack_ignored: %0d cycles left WAIT or pulsed b_done, want 0", errs);
        end
        kick_rd++;
        tick();
        total++;
        if (bus.tbl_rd_ack !== 1'b1 || bus.b_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ack_cycle: rd_ack=%b b_done=%b want 1 0", bus.tbl_rd_ack, bus.b_done);
        end
        tick();
        exp_b_rdata = ref_mem[addr];
        total++;
        if (bus.b_done !== 1'b1 || bus.a_done !== 1'b0 || bus.b_rdata !== exp_b_rdata) begin
            bad++;
            $display("[TB] FAIL late_rd_done: b_done=%b a_done=%b b_rdata=%h want 1 0 %h",
                     bus.b_done, bus.a_done, bus.b_rdata, exp_b_rdata);
        end
        bus.b_req = 1'b0;
        force_wr = 1'b0;
        silent = 1'b0;
        ref_last_b = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int waited;
        silent = 1'b1;
        bus.b_wr = 1'b0; bus.b_addr = AW'($urandom_range(0, 31)); bus.b_req = 1'b1;
`ifdef DEST_IP_TBL_ARB_TIMEOUT_EN
        waited = 0;
        do begin
            tick();
            waited++;
        end while (bus.b_done !== 1'b1 && waited < 40);
        exp_b_rdata = '0;
        total++;
        if (waited != TO + 2 || bus.b_err !== 1'b1 || bus.b_rdata !== '0) begin
            bad++;
            $display("[TB] FAIL timeout: done after %0d cycles err=%b rdata=%h want %0d 1 0",
                     waited, bus.b_err, bus.b_rdata, TO + 2);
        end
        bus.b_req = 1'b0;
        ref_last_b = 1'b1;
        tick();
`else
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i > 0 && (bus.busy !== 1'b1 || bus.b_done !== 1'b0 || bus.a_done !== 1'b0)) waited++;
        end
        total++;
        if (waited != 0) begin
            bad++;
            $display("[TB] FAIL no_timeout_hold: %0d cycles idle or done, want 0", waited);
        end
        rst_n = 1'b0;
        bus.b_req = 1'b0;
        tick();
        rst_n = 1'b1;
        ref_last_b = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        tick();
`endif
        silent = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int errs;
        silent = 1'b1;
        bus.a_wr = 1'b1; bus.a_addr = AW'($urandom_range(0, 31)); bus.a_wdata = DW'($urandom());
        bus.a_req = 1'b1;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset_busy: busy=%b want 1", bus.busy);
        end
        rst_n = 1'b0;
        bus.a_req = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.grant_b, bus.tbl_rd_req, bus.tbl_wr_req} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: busy/grant/rd/wr=%b want 0000",
                     {bus.busy, bus.grant_b, bus.tbl_rd_req, bus.tbl_wr_req});
        end
        tick();
        rst_n = 1'b1;
        ref_last_b = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        kick_wr++;
        silent = 1'b0;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.a_done !== 1'b0 || bus.busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL late_ack_ignored: %0d cycles with a_done or busy, want 0", errs);
        end
        test_fairness(2);
    endtask

    initial begin
        bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        ref_last_b  = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_fairness(4);
        test_write_read();
        test_random_single(20);
        test_fairness(6);
        test_ack_type();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
